// File: rtl/alu_2bit_checker_pkg.sv
// Shared definitions for the 2-bit Hack ALU sweep checker:
// opcode control table, sweep sizes and FSM state encoding.
package alu_2bit_checker_pkg;

  localparam int N_OPS = 18;
  localparam int N_VEC = 288;

  localparam logic [4:0] LAST_OP = 5'(N_OPS - 1);
  localparam logic [3:0] LAST_XY = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] out;
    logic       zr;
    logic       ng;
  } alu_res_t;

  // {zx,nx,zy,ny,f,no} for each opcode index
  function automatic logic [5:0] op_ctrl(input logic [4:0] op);
    logic [5:0] c;
    case (op)
      5'd0:    c = 6'b101010;
      5'd1:    c = 6'b111111;
      5'd2:    c = 6'b111010;
      5'd3:    c = 6'b001100;
      5'd4:    c = 6'b110000;
      5'd5:    c = 6'b001101;
      5'd6:    c = 6'b110001;
      5'd7:    c = 6'b001111;
      5'd8:    c = 6'b110011;
      5'd9:    c = 6'b011111;
      5'd10:   c = 6'b110111;
      5'd11:   c = 6'b001110;
      5'd12:   c = 6'b110010;
      5'd13:   c = 6'b000010;
      5'd14:   c = 6'b010011;
      5'd15:   c = 6'b000111;
      5'd16:   c = 6'b000000;
      5'd17:   c = 6'b010101;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_2bit_checker_golden.sv
// Reference model: expected Hack ALU result, zero and negative
// flags for an opcode index and 2-bit operands.
module alu_2bit_golden
  import alu_2bit_checker_pkg::*;
(
  input  logic [4:0] op,
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] res,
  output logic       zr,
  output logic       ng
);

  always_comb begin
    res = 2'd0;
    case (op)
      5'd0:    res = 2'd0;
      5'd1:    res = 2'd1;
      5'd2:    res = 2'd3;
      5'd3:    res = x;
      5'd4:    res = y;
      5'd5:    res = ~x;
      5'd6:    res = ~y;
      5'd7:    res = 2'd0 - x;
      5'd8:    res = 2'd0 - y;
      5'd9:    res = x + 2'd1;
      5'd10:   res = y + 2'd1;
      5'd11:   res = x - 2'd1;
      5'd12:   res = y - 2'd1;
      5'd13:   res = x + y;
      5'd14:   res = x - y;
      5'd15:   res = y - x;
      5'd16:   res = x & y;
      5'd17:   res = x | y;
      default: res = 2'd0;
    endcase
    zr = (res == 2'd0);
    ng = res[1];
  end

endmodule

// File: rtl/alu_2bit_checker.sv
// Exhaustive sweep checker for a 2-bit Hack ALU: drives every
// opcode/operand vector, waits to settle, compares, tallies.
module alu_2bit_checker
  import alu_2bit_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] x,
  output logic [1:0] y,
  output logic       zx,
  output logic       nx,
  output logic       zy,
  output logic       ny,
  output logic       f,
  output logic       no,
  input  logic [1:0] alu_out,
  input  logic       alu_zr,
  input  logic       alu_ng,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] fail_count,
  output logic [4:0] first_fail_op,
  output logic [1:0] first_fail_x,
  output logic [1:0] first_fail_y
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] xy_q, xy_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic [3:0] settle_q, settle_d;
  logic [8:0] fail_q, fail_d;
  logic [4:0] ffop_q, ffop_d;
  logic [1:0] ffx_q, ffx_d;
  logic [1:0] ffy_q, ffy_d;

  logic [1:0] exp_out;
  logic       exp_zr;
  logic       exp_ng;
  logic       mismatch;
  logic       last_vec;

  alu_2bit_golden u_golden (
    .op  (op_q),
    .x   (xy_q[3:2]),
    .y   (xy_q[1:0]),
    .res (exp_out),
    .zr  (exp_zr),
    .ng  (exp_ng)
  );

  assign mismatch = ({alu_out, alu_zr, alu_ng}
                     != {exp_out, exp_zr, exp_ng});
  assign last_vec = (op_q == LAST_OP) && (xy_q == LAST_XY);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    xy_d     = xy_q;
    ctrl_d   = ctrl_q;
    settle_d = settle_q;
    fail_d   = fail_q;
    ffop_d   = ffop_q;
    ffx_d    = ffx_q;
    ffy_d    = ffy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SETTLE;
          op_d     = 5'd0;
          xy_d     = 4'd0;
          ctrl_d   = op_ctrl(5'd0);
          settle_d = 4'd0;
          fail_d   = 9'd0;
          ffop_d   = 5'd0;
          ffx_d    = 2'd0;
          ffy_d    = 2'd0;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          fail_d = fail_q + 9'd1;
          if (fail_q == 9'd0) begin
            ffop_d = op_q;
            ffx_d  = xy_q[3:2];
            ffy_d  = xy_q[1:0];
          end
        end
        if (last_vec) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          // operand pair is the inner loop; opcode advances on wrap
          if (xy_q == LAST_XY) begin
            xy_d   = 4'd0;
            op_d   = op_q + 5'd1;
            ctrl_d = op_ctrl(op_q + 5'd1);
          end else begin
            xy_d = xy_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 5'd0;
      xy_q     <= 4'd0;
      ctrl_q   <= 6'd0;
      settle_q <= 4'd0;
      fail_q   <= 9'd0;
      ffop_q   <= 5'd0;
      ffx_q    <= 2'd0;
      ffy_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      xy_q     <= xy_d;
      ctrl_q   <= ctrl_d;
      settle_q <= settle_d;
      fail_q   <= fail_d;
      ffop_q   <= ffop_d;
      ffx_q    <= ffx_d;
      ffy_q    <= ffy_d;
    end
  end

  assign x = xy_q[3:2];
  assign y = xy_q[1:0];
  assign {zx, nx, zy, ny, f, no} = ctrl_q;

  assign busy = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done = (state_q == S_DONE);
  assign pass = done && (fail_q == 9'd0);

  assign fail_count    = fail_q;
  assign first_fail_op = ffop_q;
  assign first_fail_x  = ffx_q;
  assign first_fail_y  = ffy_q;

endmodule

// File: tb/tb_alu_2bit_checker.sv
// Directed bench for alu_2bit_checker with a bit-level Hack ALU
// model, fault injection and a result scoreboard.
module tb_alu_2bit_checker;

  localparam logic [5:0] CTRL_TB [0:17] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
    6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
    6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
    6'b000111, 6'b000000, 6'b010101
  };

  typedef struct {
    int         done_edge;
    logic       pass;
    logic [8:0] fails;
    logic [4:0] fop;
    logic [1:0] fx;
    logic [1:0] fy;
  } exp_t;

  exp_t sb_q[$];

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int fault_mode = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_start;
  logic [1:0] a_x, a_y, a_out;
  logic [5:0] a_ctrl;
  logic       a_zr, a_ng, a_busy, a_done, a_pass;
  logic [8:0] a_fc;
  logic [4:0] a_fop;
  logic [1:0] a_fx, a_fy;

  logic       b_reset, b_start;
  logic [1:0] b_x, b_y, b_out;
  logic [5:0] b_ctrl;
  logic       b_zr, b_ng, b_busy, b_done, b_pass;
  logic [8:0] b_fc;
  logic [4:0] b_fop;
  logic [1:0] b_fx, b_fy;

  function automatic logic [3:0] hack(input logic [5:0] c,
                                      input logic [1:0] xi,
                                      input logic [1:0] yi);
    logic [1:0] xx, yy, o;
    xx = c[5] ? 2'd0 : xi;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 2'd0 : yi;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    o  = c[0] ? ~o : o;
    return {o, o == 2'd0, o[1]};
  endfunction

  always_comb begin
    logic [3:0] r;
    r = hack(a_ctrl, a_x, a_y);
    {a_out, a_zr, a_ng} = r;
    if (fault_mode == 1)
      a_out[0] = 1'b0;
    if (fault_mode == 2 && a_ctrl == 6'b010011
        && a_x == 2'd1 && a_y == 2'd2)
      a_out = 2'd2;
  end

  always_comb {b_out, b_zr, b_ng} = hack(b_ctrl, b_x, b_y);

  alu_2bit_checker #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start),
    .x(a_x), .y(a_y),
    .zx(a_ctrl[5]), .nx(a_ctrl[4]), .zy(a_ctrl[3]),
    .ny(a_ctrl[2]), .f(a_ctrl[1]), .no(a_ctrl[0]),
    .alu_out(a_out), .alu_zr(a_zr), .alu_ng(a_ng),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail_count(a_fc), .first_fail_op(a_fop),
    .first_fail_x(a_fx), .first_fail_y(a_fy)
  );

  alu_2bit_checker #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start),
    .x(b_x), .y(b_y),
    .zx(b_ctrl[5]), .nx(b_ctrl[4]), .zy(b_ctrl[3]),
    .ny(b_ctrl[2]), .f(b_ctrl[1]), .no(b_ctrl[0]),
    .alu_out(b_out), .alu_zr(b_zr), .alu_ng(b_ng),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail_count(b_fc), .first_fail_op(b_fop),
    .first_fail_x(b_fx), .first_fail_y(b_fy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int stuck_fails();
    int c = 0;
    for (int op = 0; op < 18; op++)
      for (int p = 0; p < 16; p++) begin
        logic [3:0] pv, r;
        pv = 4'(p);
        r = hack(CTRL_TB[op], pv[3:2], pv[1:0]);
        if (r[2]) c++;
      end
    return c;
  endfunction

  task automatic pop_cmp(input string tag, input int done_at,
                         input logic ps, input logic [8:0] fc,
                         input logic [4:0] fop, input logic [1:0] fx,
                         input logic [1:0] fy, input logic bz);
    exp_t e;
    e = sb_q.pop_front();
    chk({tag, "_done_edge"}, done_at, e.done_edge);
    chk({tag, "_pass"}, ps, e.pass);
    chk({tag, "_fail_count"}, fc, e.fails);
    chk({tag, "_first_fail"}, {fop, fx, fy}, {e.fop, e.fx, e.fy});
    chk({tag, "_busy_after"}, bz, 1'b0);
  endtask

  task automatic push_exp(input int edge_n, input logic ps,
                          input int fails, input logic [4:0] fop,
                          input logic [1:0] fx, input logic [1:0] fy);
    exp_t e;
    e.done_edge = edge_n;
    e.pass = ps;
    e.fails = 9'(fails);
    e.fop = fop;
    e.fx = fx;
    e.fy = fy;
    sb_q.push_back(e);
  endtask

  task automatic run_a(input string tag, input int extra_at,
                       input int reset_at, input bit chk_vec);
    int n;
    int done_at;
    @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    n = 0;
    done_at = -1;
    if (chk_vec)
      chk({tag, "_vec0"}, {a_busy, a_ctrl, a_x, a_y},
          {1'b1, CTRL_TB[0], 4'd0});
    while (n < 700 && done_at < 0) begin
      if (n + 1 == extra_at) a_start = 1'b1;
      if (n + 1 == reset_at) a_reset = 1'b1;
      @(posedge clk);
      #1;
      n++;
      a_start = 1'b0;
      if (n == reset_at) begin
        a_reset = 1'b0;
        chk({tag, "_rst_flags"}, {a_busy, a_done, a_pass}, 3'b000);
        chk({tag, "_rst_fc"}, a_fc, 9'd0);
        chk({tag, "_rst_ff"}, {a_fop, a_fx, a_fy}, 9'd0);
        chk({tag, "_rst_drive"}, {a_ctrl, a_x, a_y}, 10'd0);
        return;
      end
      if (a_done) done_at = n;
      else if (chk_vec && n % 2 == 0 && n < 576) begin
        int k;
        k = n / 2;
        chk({tag, "_vec"}, {a_busy, a_ctrl, a_x, a_y},
            {1'b1, CTRL_TB[k / 16], 2'((k % 16) / 4), 2'(k % 4)});
      end
    end
    pop_cmp(tag, done_at, a_pass, a_fc, a_fop, a_fx, a_fy, a_busy);
  endtask

  initial begin
    int n;
    int done_at;
    a_reset = 1'b1;
    a_start = 1'b0;
    b_reset = 1'b1;
    b_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {a_busy, a_done, a_pass}, 3'b000);
    chk("reset_drive", {a_ctrl, a_x, a_y}, 10'd0);
    chk("reset_results", {a_fc, a_fop, a_fx, a_fy}, 18'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // good ALU, with an extra start mid-sweep that must be ignored
    push_exp(576, 1'b1, 0, 5'd0, 2'd0, 2'd0);
    run_a("good", 50, -1, 1'b1);
    chk("good_done_hold", a_done, 1'b1);

    // out[0] stuck at 0
    fault_mode = 1;
    push_exp(576, 1'b0, stuck_fails(), 5'd1, 2'd0, 2'd0);
    run_a("stuck0", -1, -1, 1'b0);

    // only op14 x=1 y=2 is wrong: checker must expect 3/0/1 there
    fault_mode = 2;
    push_exp(576, 1'b0, 1, 5'd14, 2'd1, 2'd2);
    run_a("op14", -1, -1, 1'b0);

    // reset mid-sweep while failures are accumulating
    fault_mode = 1;
    run_a("midrst", -1, 100, 1'b0);
    fault_mode = 0;
    push_exp(576, 1'b1, 0, 5'd0, 2'd0, 2'd0);
    run_a("after_rst", -1, -1, 1'b0);

    // reset wins over start on the same edge
    a_reset = 1'b1;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_reset = 1'b0;
    a_start = 1'b0;
    chk("rst_over_start", {a_busy, a_done}, 2'b00);

    // SETTLE_CYCLES=3 instance
    push_exp(1152, 1'b1, 0, 5'd0, 2'd0, 2'd0);
    @(posedge clk);
    #1 b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    n = 0;
    done_at = -1;
    while (n < 1300 && done_at < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (b_done) done_at = n;
    end
    pop_cmp("settle3", done_at, b_pass, b_fc, b_fop, b_fx, b_fy,
            b_busy);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
